// File: rtl/tlm_batch_drv_if.sv
// Batch load and item stream bundle for tlm_batch_drv.
// master = transactor side, slave = host loader plus DUT pins.
interface tlm_batch_drv_if #(
   parameter int NUM         = 100,
   parameter int CHANNELS    = 2,
   parameter int FIELD_WIDTH = 8,
   parameter int ITEM_WIDTH  = CHANNELS * FIELD_WIDTH,
   parameter int CNT_W       = $clog2(NUM + 1)
);
   logic                      load_valid;
   logic                      load_ready;
   logic [NUM*ITEM_WIDTH-1:0] load_data;
   logic [CNT_W-1:0]          load_count;
   logic                      out_valid;
   logic                      out_ready;
   logic [ITEM_WIDTH-1:0]     out_data;
   logic                      out_last;

   modport master (
      input  load_valid, load_data, load_count, out_ready,
      output load_ready, out_valid, out_data, out_last
   );

   modport slave (
      output load_valid, load_data, load_count, out_ready,
      input  load_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/tlm_batch_drv.sv
// Ping-pong batch transactor: whole-batch load, item-by-item stream out.
// Optional counters: define TLM_DRV_STATS_EN.
module tlm_batch_drv #(
   parameter int NUM           = 100,
   parameter int CHANNELS      = 2,
   parameter int FIELD_WIDTH   = 8,
   localparam int ITEM_WIDTH   = CHANNELS * FIELD_WIDTH,
   localparam int CNT_W        = $clog2(NUM + 1)
) (
   input  logic clk_i,
   input  logic reset_i,
   tlm_batch_drv_if.master bus,
   output logic batch_done_o,
   output logic busy_o
`ifdef TLM_DRV_STATS_EN
   ,
   output logic [31:0] items_sent_o,
   output logic [31:0] stall_cycles_o
`endif
);

   localparam int BANK_W = NUM * ITEM_WIDTH;
   localparam int BW = (BANK_W > 1) ? $clog2(BANK_W) : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q;
   logic [1:0]        full_q;
   logic              wr_sel_q;
   logic              rd_sel_q;
   logic [CNT_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q [2];
   logic [BANK_W-1:0] bank_q [2];
   logic              done_q;

   logic             load_fire;
   logic             load_take;
   logic [CNT_W-1:0] load_n;
   logic             out_fire;
   logic             is_last;
   logic [BW-1:0]    rd_base;

   assign bus.load_ready = !full_q[wr_sel_q];
   assign load_fire = bus.load_valid && bus.load_ready;
   // An empty batch completes the handshake but never claims a bank.
   assign load_take = load_fire && (bus.load_count != '0);
   assign load_n = (bus.load_count > CNT_W'(NUM))
                 ? CNT_W'(NUM) : bus.load_count;

   assign bus.out_valid = (state_q == STREAM);
   assign out_fire = bus.out_valid && bus.out_ready;
   assign is_last = (idx_q == cnt_q[rd_sel_q] - CNT_W'(1));
   assign rd_base = BW'(idx_q) * BW'(ITEM_WIDTH);
   assign bus.out_last = bus.out_valid && is_last;
   assign bus.out_data = bus.out_valid
                       ? bank_q[rd_sel_q][rd_base +: ITEM_WIDTH]
                       : '0;

   assign batch_done_o = done_q;
   assign busy_o = |full_q;

   always_ff @(posedge clk_i) begin
      if (load_take) begin
         bank_q[wr_sel_q] <= bus.load_data;
         cnt_q[wr_sel_q]  <= load_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         full_q   <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_take) begin
            full_q[wr_sel_q] <= 1'b1;
            wr_sel_q <= ~wr_sel_q;
         end
         unique case (state_q)
            IDLE: begin
               if (full_q[rd_sel_q]) state_q <= STREAM;
            end
            STREAM: begin
               if (out_fire) begin
                  if (is_last) begin
                     full_q[rd_sel_q] <= 1'b0;
                     rd_sel_q <= ~rd_sel_q;
                     idx_q    <= '0;
                     done_q   <= 1'b1;
                     // A load landing now can only target the other bank.
                     if (!(full_q[!rd_sel_q] || load_take))
                        state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

`ifdef TLM_DRV_STATS_EN
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         items_sent_o   <= '0;
         stall_cycles_o <= '0;
      end else begin
         if (out_fire)
            items_sent_o <= items_sent_o + 32'd1;
         if (bus.out_valid && !bus.out_ready)
            stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`endif

endmodule
